// File: rtl/priority_encoder_16_to_4_pkg.sv
// Shared definitions for the 16-to-4 priority encoder.
//   N       : request vector width
//   W       : encoded index width
//   state_t : presenter FSM states (IDLE: nothing offered, PRESENT: out valid)
//   idx_t   : encoded index type
package priority_encoder_16_to_4_pkg;
    localparam int N = 16;
    localparam int W = 4;

    typedef logic [W-1:0] idx_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/priority_encoder_16_to_4_pick.sv
// encoder_pick_16: combinational index picker.
//   cand  : candidate request vector
//   start : scan start pointer (round-robin mode only)
//   rr    : 1 = first set bit scanning upward from start, wrapping 15 -> 0
//           0 = highest set bit (caller ties start to 0)
//   idx   : selected index (0 when nothing is set)
//   any   : at least one candidate bit set
module encoder_pick_16
    import priority_encoder_16_to_4_pkg::*;
(
    input  logic [N-1:0] cand,
    input  idx_t         start,
    input  logic         rr,
    output idx_t         idx,
    output logic         any
);
    idx_t j;

    always_comb begin
        any = |cand;
        idx = '0;
        j   = '0;
        if (rr) begin
            // Scan farthest-first so the closest set bit at/after start wins.
            for (int i = N - 1; i >= 0; i--) begin
                j = start + W'(i);
                if (cand[j]) idx = j;
            end
        end else begin
            // Ascending scan: last hit is the highest set index.
            for (int i = 0; i < N; i++) begin
                if (cand[i]) idx = W'(i);
            end
        end
    end
endmodule

// File: rtl/priority_encoder_16_to_4.sv
// priority_encoder_16_to_4: sticky-pending priority encoder with a
// valid/ready presentation port.
//   clk, rst : clock, synchronous active-high reset
//   ena      : gates request capture and new selections
//   in       : multi-hot request vector (sampled each cycle)
//   out      : registered index being presented
//   valid    : registered, out holds a live request
//   ready    : consumer accepts out (handshake = valid && ready)
//   pending  : sticky pending-request register
// Parameter RR: 0 = fixed priority (highest index), 1 = round-robin.
module priority_encoder_16_to_4
    import priority_encoder_16_to_4_pkg::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending
);
    state_t       state, state_d;
    idx_t         out_d, ptr, ptr_d, start, pick;
    logic [N-1:0] clr, cand, pending_d;
    logic         hs, any;

    assign valid = (state == PRESENT);

    always_comb begin
        hs        = valid && ready;
        clr       = hs ? (N'(1) << out) : '0;
        // New requests are excluded from this cycle's candidates; they only
        // become eligible once they land in pending.
        cand      = pending & ~clr;
        // A re-request of the bit being cleared re-sets it here.
        pending_d = cand | (in & {N{ena}});
        // On a handshake the pointer is moving past out this same edge.
        start     = RR ? (hs ? out + idx_t'(1) : ptr) : '0;
    end

    encoder_pick_16 u_pick (
        .cand  (cand),
        .start (start),
        .rr    (RR),
        .idx   (pick),
        .any   (any)
    );

    always_comb begin
        state_d = state;
        out_d   = out;
        ptr_d   = hs ? out + idx_t'(1) : ptr;
        case (state)
            IDLE: begin
                if (ena && any) begin
                    out_d   = pick;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Without ready, out/valid hold regardless of ena or requests.
                if (ready) begin
                    if (ena && any) out_d = pick;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= '0;
            ptr     <= '0;
            pending <= '0;
        end else begin
            state   <= state_d;
            out     <= out_d;
            ptr     <= ptr_d;
            pending <= pending_d;
        end
    end
endmodule
